// File: rtl/seg_pkg.sv
// Shared segment-pattern constants and per-digit field layout for the 7-seg decoder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package seg_pkg;

  localparam int DEFAULT_NUM_DIGITS = 4;

  // Active-low segment patterns on bits6:0 (g..a); a 0 bit lights that segment.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Committed state of one digit position.
  typedef struct packed {
    logic [3:0] bcd;
    logic       valid;
    logic       blank;
    logic       err;
    logic       dp;
  } digit_t;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational lookup from an active-low 7-segment pattern to a BCD digit.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module seg7_to_bcd
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       legal,
  output logic       blank
);

  // Table lookup; anything outside the ten digits and the blank code is illegal.
  always_comb begin
    bcd   = 4'd0;
    legal = 1'b1;
    blank = 1'b0;
    case (seg)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_segment_decoder.sv
// Recovers BCD digits from a multiplexed 7-segment drive after a stability filter.
// Latency: STABLE_CYCLES+1 rising edges from a stable input change to committed outputs.
// Backpressure: none; the input is sampled every cycle and cannot be stalled.
module seven_segment_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int NUM_DIGITS    = DEFAULT_NUM_DIGITS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              seven_segment_data,
  input  logic [NUM_DIGITS-1:0]   seven_segment_enable,
  output logic [4*NUM_DIGITS-1:0] bcd_digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic [NUM_DIGITS-1:0]   pattern_error,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic                    update
);

  localparam int         IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

  logic [7:0]            samp_dat_q;
  logic [NUM_DIGITS-1:0] samp_en_q;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  update_q, update_d;
  digit_t                dig_q [NUM_DIGITS];
  digit_t                dig_d [NUM_DIGITS];
  digit_t                nd;

  logic                  sel_vld;
  logic [IDX_W-1:0]      sel_idx;
  logic                  match;
  logic [3:0]            dec_bcd;
  logic                  dec_legal;
  logic                  dec_blank;

  // The decode always looks at the held sample, which is what gets committed.
  seg7_to_bcd u_lut (
    .seg   (samp_dat_q[6:0]),
    .bcd   (dec_bcd),
    .legal (dec_legal),
    .blank (dec_blank)
  );

  // Stability counter: reload to 1 on any change, saturate at STABLE. The
  // pending flag marks the single edge where the run first reaches STABLE,
  // so a long stable run commits exactly once.
  always_comb begin
    match = (seven_segment_data == samp_dat_q) && (seven_segment_enable == samp_en_q);
    if (!match) begin
      cnt_d = 4'd1;
    end else if (cnt_q == STABLE) begin
      cnt_d = STABLE;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
    pend_d = (cnt_d == STABLE) && (cnt_q != STABLE);
  end

  // A sample selects a digit only when exactly one enable bit is low.
  always_comb begin
    int n_low;
    n_low   = 0;
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!samp_en_q[i]) begin
        n_low   = n_low + 1;
        sel_idx = IDX_W'(i);
      end
    end
    sel_vld = (n_low == 1);
  end

  // Commit the held sample into the selected digit; flag update only on a real change.
  always_comb begin
    dig_d    = dig_q;
    update_d = 1'b0;
    nd       = '0;
    if (pend_q && sel_vld) begin
      nd    = dig_q[sel_idx];
      nd.dp = ~samp_dat_q[7];
      if (dec_legal) begin
        nd.bcd   = dec_bcd;
        nd.valid = 1'b1;
        nd.blank = 1'b0;
        nd.err   = 1'b0;
      end else if (dec_blank) begin
        nd.valid = 1'b0;
        nd.blank = 1'b1;
        nd.err   = 1'b0;
      end else begin
        nd.valid = 1'b0;
        nd.blank = 1'b0;
        nd.err   = 1'b1;
      end
      dig_d[sel_idx] = nd;
      update_d       = (nd != dig_q[sel_idx]);
    end
  end

  // All state: sample register, run counter, pending-commit flag, digit fields, update pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      samp_dat_q <= '0;
      samp_en_q  <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      update_q   <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        dig_q[i] <= '0;
      end
    end else begin
      samp_dat_q <= seven_segment_data;
      samp_en_q  <= seven_segment_enable;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      update_q   <= update_d;
      dig_q      <= dig_d;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_out
    assign bcd_digits[4*g +: 4] = dig_q[g].bcd;
    assign digit_valid[g]       = dig_q[g].valid;
    assign digit_blank[g]       = dig_q[g].blank;
    assign pattern_error[g]     = dig_q[g].err;
    assign dp[g]                = dig_q[g].dp;
  end

  assign update = update_q;

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed self-checking bench for seven_segment_decoder (default parameters).
// Latency: checks commit at edge STABLE_CYCLES+1 after a stable change.
// Backpressure: n/a.
module tb_seven_segment_decoder;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  seven_segment_data   = 8'hFF;
  logic [3:0]  seven_segment_enable = 4'hF;
  logic [15:0] bcd_digits;
  logic [3:0]  digit_valid;
  logic [3:0]  digit_blank;
  logic [3:0]  pattern_error;
  logic [3:0]  dp;
  logic        update;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] segs [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  seven_segment_decoder #(
    .STABLE_CYCLES (4),
    .NUM_DIGITS    (4)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .seven_segment_data   (seven_segment_data),
    .seven_segment_enable (seven_segment_enable),
    .bcd_digits           (bcd_digits),
    .digit_valid          (digit_valid),
    .digit_blank          (digit_blank),
    .pattern_error        (pattern_error),
    .dp                   (dp),
    .update               (update)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds one data value for n edges and reports how many update pulses were seen.
  task automatic hold(input logic [7:0] d, input int n, output int ups);
    seven_segment_data = d;
    ups = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (update === 1'b1) ups++;
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      seven_segment_data   = 8'($urandom);
      seven_segment_enable = 4'($urandom);
      tick();
      n_cmp++;
      if ({bcd_digits, digit_valid, digit_blank, pattern_error, dp, update} !== 33'd0) begin
        n_bad++;
        $display("FAIL reset_clear: got bcd=%h v=%b b=%b e=%b dp=%b upd=%b want all 0",
                 bcd_digits, digit_valid, digit_blank, pattern_error, dp, update);
      end
    end
    seven_segment_enable = 4'b1110;
    seven_segment_data   = 8'hC0;
    reset = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (e < 5) begin
        n_cmp++;
        if (update !== 1'b0 || digit_valid !== 4'b0000) begin
          n_bad++;
          $display("FAIL reset_early_commit edge %0d: got upd=%b v=%b want 0/0000", e, update, digit_valid);
        end
      end else begin
        n_cmp++;
        if (update !== 1'b1 || bcd_digits[3:0] !== 4'd0 || digit_valid !== 4'b0001 || dp !== 4'b0000) begin
          n_bad++;
          $display("FAIL reset_first_commit: got upd=%b bcd0=%h v=%b dp=%b want 1/0/0001/0000",
                   update, bcd_digits[3:0], digit_valid, dp);
        end
      end
    end
    tick();
    n_cmp++;
    if (update !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_update_width: got upd=%b want 0", update);
    end
  endtask

  task automatic test_round_trip();
    int ups;
    seven_segment_enable = 4'b1101;
    for (int v = 0; v < 10; v++) begin
      hold({1'b1, segs[v]}, 6, ups);
      n_cmp++;
      if (bcd_digits[7:4] !== 4'(v) || ups !== 1 || pattern_error[1] !== 1'b0 || digit_valid[1] !== 1'b1) begin
        n_bad++;
        $display("FAIL round_trip %0d: got bcd1=%h ups=%0d err1=%b v1=%b want %0d/1/0/1",
                 v, bcd_digits[7:4], ups, pattern_error[1], digit_valid[1], v);
      end
    end
  endtask

  task automatic test_stability();
    int ups;
    seven_segment_enable = 4'b1110;
    ups = 0;
    for (int k = 0; k < 20; k++) begin
      seven_segment_data = (k % 2 == 0) ? 8'hA4 : 8'hF9;
      tick();
      if (update === 1'b1) ups++;
    end
    n_cmp++;
    if (ups !== 0 || bcd_digits[3:0] !== 4'd0 || digit_valid[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL stability_toggle: got ups=%0d bcd0=%h v0=%b want 0/0/1", ups, bcd_digits[3:0], digit_valid[0]);
    end
    seven_segment_data = 8'hA4;
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_cmp++;
      if (e < 5) begin
        if (update !== 1'b0 || bcd_digits[3:0] !== 4'd0) begin
          n_bad++;
          $display("FAIL stability_early edge %0d: got upd=%b bcd0=%h want 0/0", e, update, bcd_digits[3:0]);
        end
      end else begin
        if (update !== 1'b1 || bcd_digits[3:0] !== 4'd2) begin
          n_bad++;
          $display("FAIL stability_commit: got upd=%b bcd0=%h want 1/2", update, bcd_digits[3:0]);
        end
      end
    end
  endtask

  task automatic test_illegal_blank();
    int ups;
    seven_segment_enable = 4'b1011;
    hold(8'h92, 6, ups);
    n_cmp++;
    if (bcd_digits[11:8] !== 4'd5 || digit_valid[2] !== 1'b1 || ups !== 1) begin
      n_bad++;
      $display("FAIL digit2_five: got bcd2=%h v2=%b ups=%0d want 5/1/1", bcd_digits[11:8], digit_valid[2], ups);
    end
    hold(8'hFF, 6, ups);
    n_cmp++;
    if (digit_blank[2] !== 1'b1 || digit_valid[2] !== 1'b0 || pattern_error[2] !== 1'b0 ||
        bcd_digits[11:8] !== 4'd5 || ups !== 1) begin
      n_bad++;
      $display("FAIL digit2_blank: got b2=%b v2=%b e2=%b bcd2=%h ups=%0d want 1/0/0/5/1",
               digit_blank[2], digit_valid[2], pattern_error[2], bcd_digits[11:8], ups);
    end
    hold(8'hD5, 6, ups);
    n_cmp++;
    if (pattern_error[2] !== 1'b1 || digit_valid[2] !== 1'b0 || digit_blank[2] !== 1'b0 ||
        bcd_digits[11:8] !== 4'd5 || ups !== 1) begin
      n_bad++;
      $display("FAIL digit2_error: got e2=%b v2=%b b2=%b bcd2=%h ups=%0d want 1/0/0/5/1",
               pattern_error[2], digit_valid[2], digit_blank[2], bcd_digits[11:8], ups);
    end
    hold(8'h10, 6, ups);
    n_cmp++;
    if (bcd_digits[11:8] !== 4'd9 || dp[2] !== 1'b1 || digit_valid[2] !== 1'b1 ||
        pattern_error[2] !== 1'b0 || digit_blank[2] !== 1'b0 || ups !== 1) begin
      n_bad++;
      $display("FAIL digit2_nine_dp: got bcd2=%h dp2=%b v2=%b e2=%b b2=%b ups=%0d want 9/1/1/0/0/1",
               bcd_digits[11:8], dp[2], digit_valid[2], pattern_error[2], digit_blank[2], ups);
    end
    // Break the run, then recommit identical fields: no update expected.
    seven_segment_enable = 4'b1111;
    tick();
    seven_segment_enable = 4'b1011;
    hold(8'h10, 6, ups);
    n_cmp++;
    if (ups !== 0 || bcd_digits[11:8] !== 4'd9) begin
      n_bad++;
      $display("FAIL same_recommit: got ups=%0d bcd2=%h want 0/9", ups, bcd_digits[11:8]);
    end
  endtask

  task automatic test_select();
    int ups;
    seven_segment_enable = 4'b1100;
    hold(8'hC0, 10, ups);
    n_cmp++;
    if (ups !== 0 || bcd_digits !== 16'h0992 || digit_valid !== 4'b0111 || dp !== 4'b0100 ||
        pattern_error !== 4'b0000 || digit_blank !== 4'b0000) begin
      n_bad++;
      $display("FAIL select_two_low: got ups=%0d bcd=%h v=%b dp=%b e=%b b=%b want 0/0992/0111/0100/0000/0000",
               ups, bcd_digits, digit_valid, dp, pattern_error, digit_blank);
    end
    seven_segment_enable = 4'b1111;
    hold(8'h99, 10, ups);
    n_cmp++;
    if (ups !== 0 || bcd_digits !== 16'h0992 || digit_valid !== 4'b0111 || dp !== 4'b0100 ||
        pattern_error !== 4'b0000 || digit_blank !== 4'b0000) begin
      n_bad++;
      $display("FAIL select_none: got ups=%0d bcd=%h v=%b dp=%b e=%b b=%b want 0/0992/0111/0100/0000/0000",
               ups, bcd_digits, digit_valid, dp, pattern_error, digit_blank);
    end
    seven_segment_enable = 4'b1110;
    seven_segment_data   = 8'h99;
    tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({bcd_digits, digit_valid, digit_blank, pattern_error, dp, update} !== 33'd0) begin
      n_bad++;
      $display("FAIL midrun_reset_clear: got bcd=%h v=%b b=%b e=%b dp=%b upd=%b want all 0",
               bcd_digits, digit_valid, digit_blank, pattern_error, dp, update);
    end
    tick();
    tick();
    reset = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      n_cmp++;
      if (e < 5) begin
        if (update !== 1'b0 || digit_valid !== 4'b0000) begin
          n_bad++;
          $display("FAIL midrun_early edge %0d: got upd=%b v=%b want 0/0000", e, update, digit_valid);
        end
      end else begin
        if (update !== 1'b1 || bcd_digits[3:0] !== 4'd4 || digit_valid !== 4'b0001) begin
          n_bad++;
          $display("FAIL midrun_fresh_commit: got upd=%b bcd0=%h v=%b want 1/4/0001",
                   update, bcd_digits[3:0], digit_valid);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_stability();
    test_illegal_blank();
    test_select();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_decoder.md
SEVEN_SEGMENT_DECODER -- requirements
Module: seven_segment_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, the number of consecutive identical samples required before a digit commits (legal range 2..15).
REQ-002 SHALL have parameter NUM_DIGITS, default 4, the number of multiplexed digit positions.
REQ-003 SHALL have clk input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have reset input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have seven_segment_data input, 8 bits: active-low segments; bit7 is dp and bits6:0 are g..a.
REQ-006 SHALL have seven_segment_enable input, NUM_DIGITS bits: active-low digit select; bit i low selects digit i.
REQ-007 SHALL have bcd_digits output, 4*NUM_DIGITS bits: decoded BCD, with digit i in bits [4i+3:4i].
REQ-008 SHALL have digit_valid output, NUM_DIGITS bits: 1 means digit i holds a committed legal 0-9 pattern.
REQ-009 SHALL have digit_blank output, NUM_DIGITS bits: 1 means digit i last committed all-segments-off (0x7F on bits6:0).
REQ-010 SHALL have pattern_error output, NUM_DIGITS bits: 1 means digit i last committed a non-table, non-blank pattern.
REQ-011 SHALL have dp output, NUM_DIGITS bits: committed decimal point per digit, active-high (the inverse of data bit7).
REQ-012 SHALL have update output, 1 bit: a 1-cycle pulse when any committed output field changes.

Function
REQ-013 SHALL register seven_segment_data and seven_segment_enable into a sample register on every clock edge.
REQ-014 SHALL treat a sample as selecting digit i only when exactly one enable bit (bit i) is 0; any other enable pattern is "no select".
REQ-015 SHALL count consecutive edges on which the new sample equals the held sample; a mismatch reloads the count to 1, and the count saturates at STABLE_CYCLES.
REQ-016 SHALL commit exactly once per stable run: when the count first reaches STABLE_CYCLES and the sample is "select digit i", the fields of digit i update on the next edge.
REQ-017 SHALL hold all digits unchanged when the input is "no select", whatever its duration.
REQ-018 SHALL decode bits6:0 with this table: 0x40=0, 0x79=1, 0x24=2, 0x30=3, 0x19=4, 0x12=5, 0x02=6, 0x78=7, 0x00=8, 0x10=9.
REQ-019 SHALL, on a legal-pattern commit, set the digit value, valid=1, blank=0 and error=0.
REQ-020 SHALL, on a 0x7F commit, set blank=1, valid=0 and error=0, and keep the previous BCD value.
REQ-021 SHALL, on any other pattern commit, set error=1, valid=0 and blank=0, and keep the previous BCD value.
REQ-022 SHALL update dp[i] on every commit to digit i, independently of the segment decode.
REQ-023 SHALL assert update on the same edge the commit is written, and only if at least one of that digit's value/valid/blank/error/dp bits changed.
REQ-024 SHALL give a latency of STABLE_CYCLES+1 rising edges from an input change held stable to the committed output change.
REQ-025 SHALL produce no commit when the input changes every cycle (scan faster than STABLE_CYCLES).

Reset
REQ-026 SHALL, while reset=0, clear bcd_digits, digit_valid, digit_blank, pattern_error, dp, update, the sample register and the stability count to 0, asynchronously.
REQ-027 SHALL release reset synchronously: after reset rises, a full STABLE_CYCLES run is required before any commit.
REQ-028 SHALL discard any partially counted run when reset is asserted mid-run.

Structure
REQ-029 SHALL take the segment-pattern constants (the ten digit codes and BLANK=0x7F) and the default NUM_DIGITS from shared package seg_pkg.
REQ-030 SHALL place the combinational pattern-to-BCD lookup in sub-module seg7_to_bcd, with outputs bcd[3:0], legal and blank.
REQ-031 SHALL keep all state (sample register, count, committed fields, update) in seven_segment_decoder.

Verification
REQ-032 Reset check: reset=0 with random inputs -> all outputs 0; after reset=1, enable=1110 and data=0xC0 held -> digit0=0, valid[0]=1, update pulse at edge 5.
REQ-033 Round-trip check: sweep counts 0..9 on digit1 (enable=1101), each held 6 cycles -> bcd_digits[7:4] follows 0..9, one update per value, error=0.
REQ-034 Stability check: data alternating 0xF9/0xA4 every cycle on digit0 for 20 cycles -> no commit and no update; then 0xA4 held 4 cycles -> digit0=2 at edge 5.
REQ-035 Illegal/blank check: 0x7F on digit2 -> blank[2]=1, valid[2]=0; then 0x55 -> error[2]=1 and the BCD value is kept; then 0x10 (dp lit) -> digit2=9, dp[2]=1.
REQ-036 Select check: enable=1100 or 1111 held 10 cycles -> all outputs hold; reset pulsed at count 3 of a run -> outputs clear, and a fresh 4-sample run is needed to commit.
